// File: rtl/mem_tag_responder_pkg.sv
// Shared types and constants for the tagged memory responder: bus commands,
// tag/data widths and the completion-pipeline entry.
package mem_tag_responder_pkg;

  localparam int XLEN       = 32;
  localparam int MEM_TAG_W  = 4;
  localparam int MEM_DATA_W = 64;

  localparam logic [MEM_TAG_W-1:0] MEM_NO_TAG  = 4'h0;
  localparam logic [MEM_TAG_W-1:0] MEM_MAX_TAG = 4'hF;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef struct packed {
    logic                  valid;
    logic [MEM_TAG_W-1:0]  tag;
    logic [MEM_DATA_W-1:0] data;
  } mem_entry_t;

  // Round-robin over 1..15; tag 0 is reserved for "no tag".
  function automatic logic [MEM_TAG_W-1:0] next_tag_f(input logic [MEM_TAG_W-1:0] t);
    return (t == MEM_MAX_TAG) ? 4'h1 : t + 4'h1;
  endfunction

endpackage

// File: rtl/mem_delay_pipe.sv
// Fixed-latency shift register of completion entries {valid, tag, data};
// an entry written at edge N appears on o_entry after edge N+LATENCY-1.
module mem_delay_pipe
  import mem_tag_responder_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  mem_entry_t i_entry,
  output mem_entry_t o_entry
);

  mem_entry_t r_stage [LATENCY];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value, giving a true shift.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_entry;
      for (int i = 1; i < LATENCY; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_entry = r_stage[LATENCY-1];

endmodule

// File: rtl/mem_tag_responder.sv
// Tagged memory responder: issues a tag per accepted BUS_LOAD/BUS_STORE and
// broadcasts tag+data LATENCY cycles later. Optional MEM_BACKPRESSURE_EN adds mem_busy.
module mem_tag_responder
  import mem_tag_responder_pkg::*;
#(
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_WORDS_LOG2 = 8
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef MEM_BACKPRESSURE_EN
  input  logic                  mem_busy,
`endif
  input  BUS_COMMAND            proc2mem_command,
  input  logic [XLEN-1:0]       proc2mem_addr,
  input  logic [MEM_DATA_W-1:0] proc2mem_data,
  output logic [MEM_TAG_W-1:0]  mem2proc_response,
  output logic [MEM_DATA_W-1:0] mem2proc_data,
  output logic [MEM_TAG_W-1:0]  mem2proc_tag
);

  localparam int WORDS = 1 << ADDR_WORDS_LOG2;
  localparam logic [MEM_TAG_W-1:0] MAX_OUT = MEM_TAG_W'(MAX_OUTSTANDING);

  logic [MEM_DATA_W-1:0]      r_store [WORDS];
  logic [MEM_TAG_W-1:0]       r_next_tag;
  logic [MEM_TAG_W-1:0]       r_outstanding;
  logic [ADDR_WORDS_LOG2-1:0] w_idx;
  logic                       w_busy;
  logic                       w_completing;
  logic                       w_accept;
  logic                       w_unused_addr;
  mem_entry_t                 w_pipe_in;
  mem_entry_t                 w_pipe_out;

  assign w_idx         = proc2mem_addr[ADDR_WORDS_LOG2+2:3];
  assign w_unused_addr = ^{proc2mem_addr[XLEN-1:ADDR_WORDS_LOG2+3], proc2mem_addr[2:0]};
  assign w_completing  = w_pipe_out.valid;

`ifdef MEM_BACKPRESSURE_EN
  assign w_busy = mem_busy;
`else
  assign w_busy = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value held and no latch is inferred.
  always_comb begin
    w_accept          = 1'b0;
    w_pipe_in         = '0;
    mem2proc_response = MEM_NO_TAG;
    // A slot freed by this cycle's completion is reusable right away.
    if (reset && !w_busy && (proc2mem_command != BUS_NONE) &&
        ((r_outstanding - MEM_TAG_W'(w_completing)) < MAX_OUT)) begin
      w_accept          = 1'b1;
      mem2proc_response = r_next_tag;
      w_pipe_in.valid   = 1'b1;
      w_pipe_in.tag     = r_next_tag;
      w_pipe_in.data    = (proc2mem_command == BUS_STORE) ? proc2mem_data : r_store[w_idx];
    end
  end

  // NOTE: the backing store has no reset; contents survive reset and only a
  // plain clocked write port is needed.
  always_ff @(posedge clock) begin
    if (w_accept && (proc2mem_command == BUS_STORE)) r_store[w_idx] <= proc2mem_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_next_tag    <= 4'h1;
      r_outstanding <= '0;
    end else begin
      if (w_accept) r_next_tag <= next_tag_f(r_next_tag);
      r_outstanding <= r_outstanding + MEM_TAG_W'(w_accept) - MEM_TAG_W'(w_completing);
    end
  end

  mem_delay_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clock   (clock),
    .reset   (reset),
    .i_entry (w_pipe_in),
    .o_entry (w_pipe_out)
  );

  assign mem2proc_tag  = w_pipe_out.valid ? w_pipe_out.tag  : MEM_NO_TAG;
  assign mem2proc_data = w_pipe_out.valid ? w_pipe_out.data : '0;

endmodule

// File: tb/tb_mem_tag_responder.sv
// Randomised bench for mem_tag_responder: two instances (LATENCY 6/MAX 4 and
// LATENCY 1/MAX 15) share stimulus and are checked against an abstract model.
module tb_mem_tag_responder;
  import mem_tag_responder_pkg::*;

  localparam int NI = 2;
  localparam int LAT_A = 6, MAX_A = 4, LAT_B = 1, MAX_B = 15;
  localparam int LAT_P [NI] = '{LAT_A, LAT_B};
  localparam int MAX_P [NI] = '{MAX_A, MAX_B};
`ifdef MEM_BACKPRESSURE_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  BUS_COMMAND  cmd   = BUS_NONE;
  logic [31:0] addr  = '0;
  logic [63:0] wdata = '0;
  logic        busy  = 1'b0;
  logic [3:0]  resp  [NI];
  logic [3:0]  tagq  [NI];
  logic [63:0] rdata [NI];

  always #5 clock = ~clock;

  mem_tag_responder #(.LATENCY(LAT_A), .MAX_OUTSTANDING(MAX_A), .ADDR_WORDS_LOG2(8)) u_dut_a (
    .clock(clock), .reset(reset),
`ifdef MEM_BACKPRESSURE_EN
    .mem_busy(busy),
`endif
    .proc2mem_command(cmd), .proc2mem_addr(addr), .proc2mem_data(wdata),
    .mem2proc_response(resp[0]), .mem2proc_data(rdata[0]), .mem2proc_tag(tagq[0])
  );

  mem_tag_responder #(.LATENCY(LAT_B), .MAX_OUTSTANDING(MAX_B), .ADDR_WORDS_LOG2(8)) u_dut_b (
    .clock(clock), .reset(reset),
`ifdef MEM_BACKPRESSURE_EN
    .mem_busy(busy),
`endif
    .proc2mem_command(cmd), .proc2mem_addr(addr), .proc2mem_data(wdata),
    .mem2proc_response(resp[1]), .mem2proc_data(rdata[1]), .mem2proc_tag(tagq[1])
  );

  // Reference model: word store with known-flags, and in-flight completions
  // keyed by the absolute cycle in which they must appear.
  logic [63:0] m_mem   [NI][256];
  bit          m_known [NI][256];
  bit          f_v     [NI][64];
  logic [3:0]  f_tag   [NI][64];
  logic [63:0] f_data  [NI][64];
  bit          f_known [NI][64];
  int          m_count [NI];
  int          m_next  [NI];
  logic [3:0]  last_resp [NI];
  int          cyc   = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int s = 0; s < 64; s++) f_v[i][s] = 1'b0;
      m_count[i] = 0;
      m_next[i]  = 1;
    end
  endtask

  // Called at a falling edge: drive, check, update the model, advance one cycle.
  task automatic step(input BUS_COMMAND c, input logic [31:0] a, input logic [63:0] d, input logic b);
    int  slot;
    int  due;
    int  idx;
    bit  comp;
    bit  acc;
    cmd = c; addr = a; wdata = d; busy = b;
    #1;
    for (int i = 0; i < NI; i++) begin
      slot = cyc % 64;
      comp = f_v[i][slot];
      check($sformatf("tag%0d", i), 64'(tagq[i]), comp ? 64'(f_tag[i][slot]) : 64'h0);
      if (!comp) check($sformatf("idle_data%0d", i), rdata[i], 64'h0);
      else if (f_known[i][slot]) check($sformatf("data%0d", i), rdata[i], f_data[i][slot]);
      acc = (c != BUS_NONE) && ((m_count[i] - int'(comp)) < MAX_P[i]) && !(BP && b);
      check($sformatf("resp%0d", i), 64'(resp[i]), acc ? 64'(m_next[i]) : 64'h0);
      last_resp[i] = resp[i];
      if (comp) begin
        f_v[i][slot] = 1'b0;
        m_count[i]--;
      end
      if (acc) begin
        idx = int'(a[10:3]);
        due = (cyc + LAT_P[i]) % 64;
        f_v[i][due]   = 1'b1;
        f_tag[i][due] = 4'(m_next[i]);
        if (c == BUS_STORE) begin
          f_data[i][due]  = d;
          f_known[i][due] = 1'b1;
          m_mem[i][idx]   = d;
          m_known[i][idx] = 1'b1;
        end else begin
          f_data[i][due]  = m_mem[i][idx];
          f_known[i][due] = m_known[i][idx];
        end
        m_count[i]++;
        m_next[i] = (m_next[i] % 15) + 1;
      end
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  // Called at a falling edge: asserts reset asynchronously, holds it, releases.
  task automatic apply_reset(input int ncyc);
    cmd = BUS_LOAD; addr = 32'h10; reset = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_tag%0d", i), 64'(tagq[i]), 64'h0);
      check($sformatf("rst_data%0d", i), rdata[i], 64'h0);
      check($sformatf("rst_resp%0d", i), 64'(resp[i]), 64'h0);
    end
    model_reset();
    repeat (ncyc) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < NI; i++) check($sformatf("rst_hold_tag%0d", i), 64'(tagq[i]), 64'h0);
    reset = 1'b1;
    cmd   = BUS_NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    BUS_COMMAND c;
    logic [31:0] a;
    for (int i = 0; i < NI; i++)
      for (int w = 0; w < 256; w++) m_known[i][w] = 1'b0;
    model_reset();
    @(negedge clock);
    apply_reset(2);

    // Store then load at 0x10; aliasing 0x800 -> 0x0; 0x13 reads word 0x10.
    step(BUS_STORE, 32'h10,  64'hDEADBEEF_CAFEF00D, 1'b0);
    check("first_resp_a", 64'(last_resp[0]), 64'h1);
    step(BUS_LOAD,  32'h10,  64'h0, 1'b0);
    check("second_resp_a", 64'(last_resp[0]), 64'h2);
    step(BUS_STORE, 32'h800, 64'h0123_4567_89AB_CDEF, 1'b0);
    step(BUS_LOAD,  32'h0,   64'h0, 1'b0);
    step(BUS_LOAD,  32'h13,  64'h0, 1'b0);
    repeat (8) step(BUS_NONE, 32'h0, 64'h0, 1'b0);

    // Reset with three tags in flight; afterwards tags restart at 1.
    repeat (3) step(BUS_LOAD, 32'h10, 64'h0, 1'b0);
    apply_reset(1);

    // Back-to-back loads: instance A saturates at four outstanding.
    begin
      logic [3:0] exp_a [8];
      exp_a = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0, 4'd5, 4'd6};
      for (int k = 0; k < 8; k++) begin
        step(BUS_LOAD, 32'h10, 64'h0, 1'b0);
        check($sformatf("b2b_a_%0d", k), 64'(last_resp[0]), 64'(exp_a[k]));
        check($sformatf("b2b_b_%0d", k), 64'(last_resp[1]), 64'(k + 1));
      end
    end
    repeat (10) step(BUS_NONE, 32'h0, 64'h0, 1'b0);

`ifdef MEM_BACKPRESSURE_EN
    step(BUS_LOAD, 32'h10, 64'h0, 1'b0);
    step(BUS_LOAD, 32'h10, 64'h0, 1'b1);
    check("busy_resp_a", 64'(last_resp[0]), 64'h0);
    check("busy_resp_b", 64'(last_resp[1]), 64'h0);
    repeat (8) step(BUS_NONE, 32'h0, 64'h0, 1'b0);
`endif

    // Random traffic over a small aliased address window.
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       c = BUS_NONE;
        3:       c = BUS_STORE;
        default: c = BUS_LOAD;
      endcase
      a = (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 15)) << 3) |
          32'($urandom_range(0, 7));
      step(c, a, {$urandom, $urandom}, ($urandom_range(0, 4) == 0));
    end
    repeat (20) step(BUS_NONE, 32'h0, 64'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_tag_responder.md
Name: mem_tag_responder

Overview:
Memory-side responder for the tagged BUS_COMMAND protocol issued by the I/D cache controllers. It accepts one BUS_LOAD/BUS_STORE per cycle. In the same cycle it returns a nonzero response tag (1..15), or 0 when it rejects the request. Exactly LATENCY cycles later it broadcasts that tag with the 64-bit data. It holds a synthesizable word-addressed backing store and replaces the behavioural memory model in cache-level benches.

Parameters:
LATENCY, 4, cycles from accept to tag broadcast; legal range 1..15
MAX_OUTSTANDING, 4, maximum requests in flight; legal range 1..15
ADDR_WORDS_LOG2, 8, log2 of the number of 64-bit words in the backing store

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
proc2mem_command  input  BUS_COMMAND  BUS_NONE / BUS_LOAD / BUS_STORE
proc2mem_addr  input  XLEN  byte address; bits [2:0] ignored
proc2mem_data  input  64  store data
mem2proc_response  output  4  tag allocated this cycle; 0 = rejected or no request
mem2proc_data  output  64  load data; valid when mem2proc_tag != 0
mem2proc_tag  output  4  completing tag; 0 = no completion this cycle

Behaviour:
- Reset: asynchronous assert and active-low; reset is the only asynchronous signal.
  - While reset is low: all pipeline entries are invalid, the outstanding count is 0, next_tag = 1, mem2proc_tag = 0 and mem2proc_data = 0.
  - Backing-store contents are not reset.
  - mem2proc_response is 0 while reset is asserted.
- Word index = proc2mem_addr[ADDR_WORDS_LOG2+2:3]. Higher address bits are ignored, so addresses wrap modulo the store size.
- Accept condition (combinational, same cycle): command != BUS_NONE AND (outstanding - completing_this_cycle) < MAX_OUTSTANDING.
  - On accept: mem2proc_response = next_tag.
  - Otherwise: mem2proc_response = 0. A rejected request has no side effects; the initiator retries.
- Tag allocation is round-robin 1,2,...,15,1,... and never yields 0. next_tag advances only on accept. Because MAX_OUTSTANDING <= 15, tags in flight are always unique.
- BUS_STORE accept: store[idx] <= proc2mem_data at the accepting clock edge. A tag is still issued and completes with mem2proc_data = the stored value.
- BUS_LOAD accept: data is read at the accept edge. The read sees all stores accepted in earlier cycles, not the same-cycle store.
- Completion pipeline: LATENCY stages of {valid, tag, data}.
  - An entry accepted at edge N drives mem2proc_tag/mem2proc_data during the cycle following edge N+LATENCY-1. Example: with LATENCY=1, an entry accepted at edge N is visible right after edge N.
  - Outputs are registered.
  - Because accepts are at most one per cycle and latency is fixed, completions never collide and are at most one per cycle.
- Outstanding count:
  - +1 on accept, -1 on completion; both in the same cycle leaves it unchanged.
  - A slot freed by a completion in cycle C is reusable by an accept in cycle C.
- mem2proc_data = 0 whenever mem2proc_tag = 0.

Optional Feature:
MEM_BACKPRESSURE_EN
- Defined: adds an input port mem_busy (1 bit). While mem_busy is high, the accept condition is forced false, so mem2proc_response = 0 and there are no side effects. In-flight completions continue unaffected. This models DCache-priority rejection of ICache requests.
- Undefined: the port is absent and only the MAX_OUTSTANDING limit causes rejection.

Decomposition:
- Shared package/header:
  - existing BUS_COMMAND enum
  - MEM_TAG_W = 4
  - MEM_NO_TAG = 4'h0
  - MEM_MAX_TAG = 4'hF
  - MEM_DATA_W = 64
- One sub-module: mem_delay_pipe, a parameterized LATENCY-deep shift register of {valid, tag, data} with asynchronous active-low reset. The top level contains the storage, accept logic, tag counter and outstanding counter.

Test Plan:
- Reset low mid-flight with 3 tags outstanding -> next cycle mem2proc_tag = 0. After release, the first accepted LOAD returns response 1 and no stale tag ever appears.
- STORE addr 0x10, data 0xDEADBEEF_CAFEF00D at cycle 0, then LOAD addr 0x10 at cycle 1 (LATENCY = 4) -> responses 1 and 2. Tag 1 appears in cycle 4, tag 2 with the same data in cycle 5.
- Back-to-back LOADs every cycle with MAX_OUTSTANDING = 4, LATENCY = 6 -> the first four cycles get tags 1..4, and the following cycles get response 0 until tag 1 completes. In the cycle tag 1 completes, a new request is accepted with tag 5.
- 20 consecutive accepted requests with LATENCY = 1 -> tags issue 1..15 then 1..5, never 0, and each completes exactly one cycle after its accept.
- Addresses 0x0 and 0x800 (ADDR_WORDS_LOG2 = 8) -> aliasing: a STORE to 0x800 is read back by a LOAD to 0x0. The address 0x13 reads the same word as 0x10.
- MEM_BACKPRESSURE_EN defined: mem_busy = 1 during a LOAD -> response 0, no state change. A completion already in flight still appears on schedule.
